ram_fifo_ctrl4x8: RTL and testbench
===================================

# ram_fifo_ctrl4x8

Single-port FIFO controller sitting directly upstream of the 4-word x 8-bit JK-flip-flop RAM (`ram4x8`). It accepts bytes on a valid/ready input port, stores them in the RAM by driving its `write`, `address1`, `address2` and data inputs, and reads them back into a one-word output register presented on a valid/ready output port. The RAM has one address port, so the controller arbitrates one RAM operation (write or read) per clock.

## Interface
- `WIDTH`, 8: data width; equals the RAM word width.
- `DEPTH`, 4: RAM words; fixed at 4 (2-bit address).
- `clk` in 1: clock, rising edge; also drives RAM `clk`.
- `clear` in 1: reset, asynchronous, active-high; also wired to RAM `clear`.
- `in_valid` in 1: producer has a byte on `in_data`.
- `in_ready` out 1: byte accepted at this rising edge when `in_valid & in_ready`.
- `in_data` in WIDTH: input byte.
- `out_valid` out 1: `out_data` holds a valid byte.
- `out_ready` in 1: consumer takes the byte at this edge when `out_valid & out_ready`.
- `out_data` out WIDTH: head-of-FIFO byte (registered).
- `ram_write` out 1: to RAM `write`.
- `ram_addr` out 2: `[1]` to RAM `address1`, `[0]` to RAM `address2`.
- `ram_din` out WIDTH: to RAM `in1..in8` (`[7]` = `in1`).
- `ram_dout` in WIDTH: from RAM `s1..s8` (`[7]` = `s1`).
- `count` out 3: total occupancy, `mem_count + out_valid`, range 0..5.

## Operation
- Registered state: `wr_ptr`, `rd_ptr` (2 bits, wrap 3->0), `mem_count` (0..4), output register (`out_valid`, `out_data`), priority bit `pri` (0 = read first), `op` of the current cycle.
- `op` states: `OP_IDLE`, `OP_WRITE`, `OP_READ`; chosen combinationally each cycle from registered state and `in_valid`, `out_ready`.
- Write eligible: `in_valid & (mem_count < 4)`.
- Read eligible: `(mem_count > 0) & (~out_valid | out_ready)`.
- Only one eligible -> that op. Both -> `OP_READ` if `pri==0`, else `OP_WRITE`; `pri` toggles after every contended cycle, unchanged otherwise. Neither -> `OP_IDLE`.
- `OP_WRITE`: `in_ready=1`, `ram_write=1`, `ram_addr=wr_ptr`, `ram_din=in_data`; at edge RAM stores, `wr_ptr++`, `mem_count++`.
- `OP_READ`: `ram_write=0`, `ram_addr=rd_ptr`; at edge `out_data<=ram_dout`, `out_valid<=1`, `rd_ptr++`, `mem_count--`.
- `OP_IDLE`: `ram_write=0`, `ram_addr=rd_ptr`, `in_ready=0`.
- Consumer pop without a read this cycle: `out_valid<=0`, `out_data` holds.
- `ram_din` always equals `in_data`; `in_ready` equals 1 only in `OP_WRITE`.
- Full (`mem_count==4`): `in_ready=0`. Empty (`count==0`): `out_valid=0`.

## Timing
- Reset (async, while `clear`=1): `wr_ptr=rd_ptr=0`, `mem_count=0`, `pri=0`, `out_valid=0`, `out_data=0`, `count=0`; `in_ready=0`, `ram_write=0`, `ram_addr=0` forced combinationally while `clear` is high. Reset mid-write discards the word; RAM contents are cleared by the same `clear`.
- Accept-to-`out_valid` latency (no bypass, idle FIFO): byte accepted at edge N, read at edge N+1, `out_valid=1` after edge N+1.
- Pop and refill same edge: full throughput of one byte per cycle on the output while `mem_count>0` and no contention.
- Contention sustained: reads and writes alternate, 1 byte per 2 cycles each direction.
- `ram_write`/`ram_addr` must be stable before the rising edge; `in_valid` must not change within a cycle (RAM gates clock with `write`).

## Configuration
- `RAM_FIFO_BYPASS_EN` defined: when `mem_count==0` and (`~out_valid` or `out_ready`) and `in_valid`, the byte goes straight to `out_data` at the accepting edge (`in_ready=1`, `ram_write=0`, `op=OP_IDLE`, pointers unchanged); latency 1 edge; `pri` not affected.
- Undefined: every byte passes through the RAM; latency as in Timing.

## Structure
- Package `ram_fifo_pkg`: `op_t` (`OP_IDLE`, `OP_WRITE`, `OP_READ`), `FIFO_WIDTH=8`, `FIFO_DEPTH=4`, `FIFO_AW=2`.
- One sub-module `ptr_ctr2`: 2-bit wrap counter with increment enable and async active-high clear, instantiated for `wr_ptr` and `rd_ptr`.
- Bench instantiates `ram4x8` and this block together.

## Test plan
- Reset: `clear=1` at t=0, release at 5 -> all outputs 0, `count=0`, `ram_write` never 1 during reset.
- Fill: push 0x11,0x22,0x33,0x44,0x55 with `out_ready=0` -> `count` reaches 5, then `in_ready=0`; pop all -> 0x11..0x55 in order.
- Wrap: 10 push/pop pairs of 0xA0..0xA9 -> output order preserved across pointer wrap 3->0.
- Contention: `in_valid=1`, `out_ready=1`, `mem_count=2` -> ops alternate READ,WRITE,READ... starting with READ after reset.
- Reset mid-operation: `clear` pulse with `count=3` -> `count=0`, `out_valid=0` immediately; next push 0x5A pops as 0x5A.
- Bypass (macro defined): push 0x7E into empty FIFO -> `out_valid=1`, `out_data=0x7E` after 1 edge, `ram_write` stays 0.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// ===========================================================================
// ram_fifo_pkg : shared types/constants for the ram4x8 FIFO controller | rev 1.0
// ===========================================================================
`default_nettype none

package ram_fifo_pkg;

  typedef enum logic [1:0] {
    OP_IDLE  = 2'd0,
    OP_WRITE = 2'd1,
    OP_READ  = 2'd2
  } op_t;

  localparam int FIFO_WIDTH = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int FIFO_AW    = 2;

endpackage

`default_nettype wire

// File: rtl/ptr_ctr2.sv
// ===========================================================================
// ptr_ctr2 : 2-bit wrapping pointer with increment enable, async clear | rev 1.0
// ===========================================================================
`default_nettype none

module ptr_ctr2
  import ram_fifo_pkg::*;
(
  input  logic               clk,
  input  logic               clear,
  input  logic               inc,
  output logic [FIFO_AW-1:0] q
);

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      q <= '0;
    end else if (inc) begin
      q <= q + FIFO_AW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/ram_fifo_ctrl4x8.sv
// ===========================================================================
// ram_fifo_ctrl4x8 : one-op-per-cycle FIFO controller in front of ram4x8;
// optional direct path to the output register via RAM_FIFO_BYPASS_EN | rev 1.0
// ===========================================================================
`default_nettype none

module ram_fifo_ctrl4x8
  import ram_fifo_pkg::*;
#(
  parameter int WIDTH = FIFO_WIDTH,
  parameter int DEPTH = FIFO_DEPTH
) (
  input  logic               clk,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               ram_write,
  output logic [FIFO_AW-1:0] ram_addr,
  output logic [WIDTH-1:0]   ram_din,
  input  logic [WIDTH-1:0]   ram_dout,
  output logic [2:0]         count
);

  logic [FIFO_AW-1:0] wr_ptr;
  logic [FIFO_AW-1:0] rd_ptr;
  logic [2:0]         mem_count;
  logic               pri;
  op_t                op;
  logic               wr_elig;
  logic               rd_elig;
  logic               contend;
  logic               bypass;

  always_comb begin
    wr_elig = in_valid && (mem_count < 3'(DEPTH));
    rd_elig = (mem_count != 3'd0) && (!out_valid || out_ready);
    contend = wr_elig && rd_elig;
`ifdef RAM_FIFO_BYPASS_EN
    bypass  = in_valid && (mem_count == 3'd0) && (!out_valid || out_ready);
`else
    bypass  = 1'b0;
`endif
    op = OP_IDLE;
    if (bypass) begin
      op = OP_IDLE;
    end else if (contend) begin
      op = pri ? OP_WRITE : OP_READ;
    end else if (wr_elig) begin
      op = OP_WRITE;
    end else if (rd_elig) begin
      op = OP_READ;
    end
  end

  // RAM controls are forced quiet while clear is high so the RAM never latches a write.
  always_comb begin
    in_ready  = !clear && ((op == OP_WRITE) || bypass);
    ram_write = !clear && (op == OP_WRITE);
    ram_addr  = clear ? '0 : ((op == OP_WRITE) ? wr_ptr : rd_ptr);
    ram_din   = in_data;
    count     = mem_count + {2'b00, out_valid};
  end

  ptr_ctr2 u_wr_ptr (
    .clk   (clk),
    .clear (clear),
    .inc   (op == OP_WRITE),
    .q     (wr_ptr)
  );

  ptr_ctr2 u_rd_ptr (
    .clk   (clk),
    .clear (clear),
    .inc   (op == OP_READ),
    .q     (rd_ptr)
  );

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      mem_count <= 3'd0;
      pri       <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (op)
        OP_WRITE: mem_count <= mem_count + 3'd1;
        OP_READ:  mem_count <= mem_count - 3'd1;
        default:  mem_count <= mem_count;
      endcase
      if (contend) begin
        pri <= ~pri;
      end
      if (op == OP_READ) begin
        out_data  <= ram_dout;
        out_valid <= 1'b1;
      end else if (bypass) begin
        out_data  <= in_data;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ram_fifo_ctrl4x8.sv
// ===========================================================================
// tb_ram_fifo_ctrl4x8 : ram_fifo_ctrl4x8 with a behavioural 4x8 RAM, checked
// against a queue-based reference model | rev 1.0
// ===========================================================================
`default_nettype none

module tb_ram_fifo_ctrl4x8;

  logic       clk = 1'b0;
  logic       clear;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       ram_write;
  logic [1:0] ram_addr;
  logic [7:0] ram_din;
  logic [7:0] ram_dout;
  logic [2:0] count;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  ram_fifo_ctrl4x8 dut (
    .clk       (clk),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .ram_write (ram_write),
    .ram_addr  (ram_addr),
    .ram_din   (ram_din),
    .ram_dout  (ram_dout),
    .count     (count)
  );

  // Stand-in for ram4x8: combinational read, write on the rising edge, cleared by clear.
  logic [7:0] ram_mem [0:3];
  always @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < 4; i++) ram_mem[i] <= 8'h00;
    end else if (ram_write) begin
      ram_mem[ram_addr] <= ram_din;
    end
  end
  assign ram_dout = ram_mem[ram_addr];

  // Reference model: bytes held in RAM as a queue, plus the output register.
  byte unsigned m_q[$];
  bit           m_ov;
  logic [7:0]   m_od;
  bit           m_pri;
  int           m_wr;
  int           m_rd;
  int           p_op;       // 0 idle, 1 write, 2 read
  bit           p_byp;
  bit           p_contend;

  function automatic void model_reset();
    m_q.delete();
    m_ov  = 1'b0;
    m_od  = 8'h00;
    m_pri = 1'b0;
    m_wr  = 0;
    m_rd  = 0;
  endfunction

  function automatic void predict(input bit iv, input bit ordy);
    bit we;
    bit re;
    we = iv && (m_q.size() < 4);
    re = (m_q.size() > 0) && (!m_ov || ordy);
    p_byp = 1'b0;
`ifdef RAM_FIFO_BYPASS_EN
    p_byp = iv && (m_q.size() == 0) && (!m_ov || ordy);
`endif
    p_contend = we && re && !p_byp;
    if (p_byp)          p_op = 0;
    else if (we && re)  p_op = m_pri ? 1 : 2;
    else if (we)        p_op = 1;
    else if (re)        p_op = 2;
    else                p_op = 0;
  endfunction

  function automatic void commit(input bit ordy, input logic [7:0] d);
    if (p_op == 2) begin
      m_od = m_q.pop_front();
      m_ov = 1'b1;
      m_rd++;
    end else if (p_byp) begin
      m_od = d;
      m_ov = 1'b1;
    end else if (m_ov && ordy) begin
      m_ov = 1'b0;
    end
    if (p_op == 1) begin
      m_q.push_back(d);
      m_wr++;
    end
    if (p_contend) m_pri = !m_pri;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at posedge+1, check controls mid-cycle, check registers at next posedge+1.
  task automatic step(input bit iv, input logic [7:0] d, input bit ordy, output bit acc);
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    predict(iv, ordy);
    #4;
    chk("in_ready",  {31'd0, in_ready},  {31'd0, (p_op == 1) || p_byp});
    chk("ram_write", {31'd0, ram_write}, {31'd0, p_op == 1});
    chk("ram_addr",  {30'd0, ram_addr},  {30'd0, 2'((p_op == 1) ? m_wr % 4 : m_rd % 4)});
    acc = (p_op == 1) || p_byp;
    @(posedge clk);
    commit(ordy, d);
    #1;
    chk("out_valid", {31'd0, out_valid}, {31'd0, m_ov});
    chk("out_data",  {24'd0, out_data},  {24'd0, m_od});
    chk("count",     {29'd0, count},     32'(m_q.size()) + {31'd0, m_ov});
  endtask

  task automatic push(input logic [7:0] d, input bit ordy);
    bit acc;
    for (int k = 0; k < 12; k++) begin
      step(1'b1, d, ordy, acc);
      if (acc) return;
    end
    vectors++;
    miscompares++;
    $error("FAIL push_timeout: observed no accept expected accept of %0h", d);
  endtask

  task automatic pop(input logic [7:0] exp);
    bit acc;
    bit got;
    logic [7:0] b;
    for (int k = 0; k < 12; k++) begin
      got = m_ov;
      b   = out_data;
      step(1'b0, 8'h00, 1'b1, acc);
      if (got) begin
        chk("pop_data", {24'd0, b}, {24'd0, exp});
        return;
      end
    end
    vectors++;
    miscompares++;
    $error("FAIL pop_timeout: observed no byte expected %0h", exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] fill_vals [0:4];
    bit acc;
    fill_vals[0] = 8'h11; fill_vals[1] = 8'h22; fill_vals[2] = 8'h33;
    fill_vals[3] = 8'h44; fill_vals[4] = 8'h55;

    // Reset with a pending producer byte that must not reach the RAM.
    clear = 1'b1; in_valid = 1'b1; in_data = 8'h99; out_ready = 1'b1;
    model_reset();
    #2;
    chk("rst_ram_write", {31'd0, ram_write}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd0);
    chk("rst_ram_addr",  {30'd0, ram_addr},  32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_data",  {24'd0, out_data},  32'd0);
    chk("rst_count",     {29'd0, count},     32'd0);
    #2;
    chk("rst_ram_write2", {31'd0, ram_write}, 32'd0);
    in_valid = 1'b0; out_ready = 1'b0;
    #1 clear = 1'b0;
    #1;

    // Fill to five bytes, confirm full back-pressure, then drain in order.
    for (int i = 0; i < 5; i++) push(fill_vals[i], 1'b0);
    chk("fill_count", {29'd0, count}, 32'd5);
    step(1'b1, 8'h66, 1'b0, acc);
    chk("full_in_ready", {31'd0, acc}, 32'd0);
    for (int i = 0; i < 5; i++) pop(fill_vals[i]);

    // Pointer wrap.
    for (int i = 0; i < 10; i++) begin
      push(8'hA0 + 8'(i), 1'b0);
      pop(8'hA0 + 8'(i));
    end

    // Contention: two words in RAM, producer and consumer both active.
    push(8'hC1, 1'b0);
    push(8'hC2, 1'b0);
    push(8'hC3, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b1, 8'hD0 + 8'(i), 1'b1, acc);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, acc);

    // Clear pulse with three bytes held.
    push(8'h01, 1'b0);
    push(8'h02, 1'b0);
    push(8'h03, 1'b0);
    chk("pre_clear_count", {29'd0, count}, 32'd3);
    in_valid = 1'b1; in_data = 8'h04; out_ready = 1'b0;
    #2 clear = 1'b1;
    #1;
    chk("clr_count",     {29'd0, count},     32'd0);
    chk("clr_out_valid", {31'd0, out_valid}, 32'd0);
    chk("clr_ram_write", {31'd0, ram_write}, 32'd0);
    model_reset();
    in_valid = 1'b0;
    #1 clear = 1'b0;
    @(posedge clk);
    #1;
    push(8'h5A, 1'b0);
    pop(8'h5A);

`ifdef RAM_FIFO_BYPASS_EN
    step(1'b1, 8'h7E, 1'b0, acc);
    chk("byp_out_valid", {31'd0, out_valid}, 32'd1);
    chk("byp_out_data",  {24'd0, out_data},  32'h7E);
    pop(8'h7E);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom), 8'($urandom), 1'($urandom_range(0, 2) != 0), acc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
